control_datapath: RTL and testbench
===================================

# control_datapath

Multicycle RV32I integer core slice: a `control` FSM plus a `datapath` (PC, IR, register file, ALU, word data memory) in one clock domain. The instruction word comes in on a port, not from memory. The FSM sequences each instruction through fetch, decode, execute, memory and writeback states and drives all datapath enables and muxes. Debug outputs expose PC, ALU result, IR and FSM state to the top-level bench.

## Interface
- No parameters. Fixed sizes: 32 registers of 32 bits, data memory of 1024 words of 32 bits.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: reset port named `reset`, asynchronous and active-low.
- `instr` in 32: current instruction word, sampled into IR in FETCH.
- `instr_out` out 32: IR contents.
- `d_pc_out` out 32: PC register.
- `d_alu_result` out 32: combinational ALU result.
- `current_state` out 4: FSM state code.
- Control outputs, each 1 bit: `mem_write`, `reg_write`, `ir_write`, `pc_write`, `instruction_or_data`.
- Control outputs, 2 bits: `result_src`, `alu_src_a`, `alu_src_b`. Control output, 3 bits: `alu_control`.
- Hierarchically visible arrays: `reg_file[0:31]` and `mem[0:1023]`, 32 bits each. The bench may write or read them directly.

## Operation
- Supported opcodes:
  - R-type 0110011: add, sub, slt, or, and.
  - I-ALU 0010011: addi, slti, ori, andi.
  - lw 0000011, sw 0100011.
- Internal registers: PC, OldPC, IR, A, B, ALUOut, Data.
- A and B load `reg_file[IR[19:15]]` and `reg_file[IR[24:20]]` every cycle.
- ALUOut loads the ALU result every cycle.
- Immediates, sign-extended:
  - I-type: IR[31:20].
  - S-type: {IR[31:25], IR[11:7]}.
- Mux codes:
  - `alu_src_a`: 00 = PC, 01 = OldPC, 10 = A.
  - `alu_src_b`: 00 = B, 01 = immediate, 10 = constant 4.
  - `result_src`: 00 = ALUOut, 01 = Data, 10 = ALU result.
  - `instruction_or_data`: 0 = PC, 1 = ALUOut (memory address select).
- `alu_control` codes: 000 add, 001 sub, 010 and, 011 or, 101 slt (signed, result 1 or 0). Arithmetic wraps modulo 2^32.
- ALU decode, by funct3:
  - 000: sub when R-type and funct7[5]=1, otherwise add.
  - 010: slt. 110: or. 111: and.
  - Any other funct3: add.
- Memory word index = address[11:2]; address bits above bit 11 are ignored (index wraps).
- Writes to x0 are ignored; x0 always reads 0.
- FSM states:
  - FETCH 0: `ir_write`=1, `pc_write`=1, src_a=00, src_b=10, add, result_src=10. Updates IR←instr, OldPC←PC, PC←PC+4.
  - DECODE 1: no enables. Goes to MEMADR (lw/sw), EXECUTER (R), EXECUTEI (I-ALU); any other opcode returns to FETCH.
  - MEMADR 2: src_a=10, src_b=01, add. Goes to MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD 3: `instruction_or_data`=1; Data←mem. Goes to MEMWB.
  - MEMWB 4: result_src=01, `reg_write`=1, writes rd. Goes to FETCH.
  - MEMWRITE 5: `instruction_or_data`=1, `mem_write`=1; mem←B. Goes to FETCH.
  - EXECUTER 6: src_a=10, src_b=00, decoded op. Goes to ALUWB.
  - ALUWB 7: result_src=00, `reg_write`=1. Goes to FETCH.
  - EXECUTEI 8: src_a=10, src_b=01, decoded op. Goes to ALUWB.
- Undefined state codes go to FETCH.
- Control outputs are Moore (decoded from state and IR). Enables default to 0, muxes default to 00, `alu_control` defaults to 000.

## Timing
- Reset asserted (low) forces, immediately: state=FETCH, PC=0, OldPC=0, IR=0, A=B=ALUOut=Data=0, all `reg_file` and `mem` entries 0.
- Outputs while reset is asserted: `d_pc_out`=0, `instr_out`=0, `current_state`=0, FETCH control values.
- Reset asserted mid-instruction aborts it; no pending register or memory write occurs.
- Latency in cycles: R and I-ALU 4, lw 5, sw 4.
- Register and memory writes commit at the rising edge that ends MEMWB, ALUWB or MEMWRITE.
- An instr change is seen only at the next FETCH.
- If instr is held constant, the same instruction re-executes every pass and PC advances by 4 per instruction.

## Test plan
- Reset release, instr=NOP addi: PC=0, state 0 during reset; PC=4 after the first FETCH edge.
- reg x1=0x18, x2=1, instr=0x002081B3 (add x3,x1,x2) -> x3=0x19 after 4 cycles; states 0,1,6,7 repeat; PC +4 per instruction.
- sub x3,x1,x2 with the same values -> x3=0x17. slt x3,x2,x1 -> 1. or -> 0x19. and -> 0.
- x2=0x10, sw x1,0(x2) -> mem[4]=0x18 after 4 cycles. Then lw x5,0(x2) -> x5=0x18 after 5 cycles (states 0,1,2,3,4).
- addi x0,x1,5 -> x0 stays 0. addi x4,x1,-1 -> x4=0x17.
- Reset asserted during EXECUTER -> state 0, PC=0, rd unchanged (0).

Source files
------------

// File: rtl/control_datapath.sv
// Multicycle RV32I core slice: a Moore control FSM sequencing a PC/IR/register-file/ALU
// datapath with a word-addressed data memory. The instruction word arrives on a port.
module control_datapath (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  output logic [31:0] instr_out,
  output logic [31:0] d_pc_out,
  output logic [31:0] d_alu_result,
  output logic [3:0]  current_state,
  output logic        mem_write,
  output logic        reg_write,
  output logic        ir_write,
  output logic        pc_write,
  output logic        instruction_or_data,
  output logic [1:0]  result_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_control
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    ALUWB    = 4'd7,
    EXECUTEI = 4'd8
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  state_t state, next_state;

  logic [31:0] pc, old_pc, ir, a, b, alu_out, data;
  logic [31:0] reg_file [0:31];
  logic [31:0] mem [0:1023];

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  decoded_op;
  logic [31:0] imm, src_a, src_b, alu_result, result, addr;
  logic [9:0]  mem_index;
  logic        addr_unused;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign rd     = ir[11:7];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];

  always_comb begin
    case (funct3)
      3'b000:  decoded_op = (opcode == OP_R && ir[30]) ? 3'b001 : 3'b000;
      3'b010:  decoded_op = 3'b101;
      3'b110:  decoded_op = 3'b011;
      3'b111:  decoded_op = 3'b010;
      default: decoded_op = 3'b000;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state          = FETCH;
    mem_write           = 1'b0;
    reg_write           = 1'b0;
    ir_write            = 1'b0;
    pc_write            = 1'b0;
    instruction_or_data = 1'b0;
    result_src          = 2'b00;
    alu_src_a           = 2'b00;
    alu_src_b           = 2'b00;
    alu_control         = 3'b000;
    case (state)
      FETCH: begin
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        next_state = DECODE;
      end
      DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: next_state = MEMADR;
          OP_R:              next_state = EXECUTER;
          OP_I:              next_state = EXECUTEI;
          default:           next_state = FETCH;
        endcase
      end
      MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        next_state = (opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        instruction_or_data = 1'b1;
        next_state          = MEMWB;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      MEMWRITE: begin
        instruction_or_data = 1'b1;
        mem_write           = 1'b1;
      end
      EXECUTER: begin
        alu_src_a   = 2'b10;
        alu_control = decoded_op;
        next_state  = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
      end
      EXECUTEI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = decoded_op;
        next_state  = ALUWB;
      end
      default: next_state = FETCH;
    endcase
  end

  // Stores use the split S-type immediate; every other format here is I-type.
  assign imm = (opcode == OP_STORE) ? {{20{ir[31]}}, ir[31:25], ir[11:7]}
                                    : {{20{ir[31]}}, ir[31:20]};

  always_comb begin
    case (alu_src_a)
      2'b01:   src_a = old_pc;
      2'b10:   src_a = a;
      default: src_a = pc;
    endcase
    case (alu_src_b)
      2'b01:   src_b = imm;
      2'b10:   src_b = 32'd4;
      default: src_b = b;
    endcase
    case (alu_control)
      3'b001:  alu_result = src_a - src_b;
      3'b010:  alu_result = src_a & src_b;
      3'b011:  alu_result = src_a | src_b;
      3'b101:  alu_result = {31'd0, $signed(src_a) < $signed(src_b)};
      default: alu_result = src_a + src_b;
    endcase
    case (result_src)
      2'b01:   result = data;
      2'b10:   result = alu_result;
      default: result = alu_out;
    endcase
  end

  assign addr        = instruction_or_data ? alu_out : pc;
  assign mem_index   = addr[11:2];
  assign addr_unused = ^{addr[31:12], addr[1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= '0;
      old_pc  <= '0;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      data    <= '0;
      for (int i = 0; i < 32; i++)   reg_file[i] <= '0;
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
    end else begin
      a       <= reg_file[rs1];
      b       <= reg_file[rs2];
      alu_out <= alu_result;
      data    <= mem[mem_index];
      if (ir_write) begin
        ir     <= instr;
        old_pc <= pc;
      end
      if (pc_write) pc <= result;
      // x0 is never written, so it keeps reading back as zero.
      if (reg_write && rd != 5'd0) reg_file[rd] <= result;
      if (mem_write) mem[mem_index] <= b;
    end
  end

  assign instr_out     = ir;
  assign d_pc_out      = pc;
  assign d_alu_result  = alu_result;
  assign current_state = state;

endmodule

// File: tb/tb_control_datapath.sv
// Scoreboard bench for control_datapath: stimulus queues expected state sequences and
// post-instruction results; a negedge monitor pops and compares them against the DUT.
module tb_control_datapath;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic [31:0] instr_out, d_pc_out, d_alu_result;
  logic [3:0]  current_state;
  logic        mem_write, reg_write, ir_write, pc_write, instruction_or_data;
  logic [1:0]  result_src, alu_src_a, alu_src_b;
  logic [2:0]  alu_control;

  control_datapath dut (
    .clk                 (clk),
    .reset               (reset),
    .instr               (instr),
    .instr_out           (instr_out),
    .d_pc_out            (d_pc_out),
    .d_alu_result        (d_alu_result),
    .current_state       (current_state),
    .mem_write           (mem_write),
    .reg_write           (reg_write),
    .ir_write            (ir_write),
    .pc_write            (pc_write),
    .instruction_or_data (instruction_or_data),
    .result_src          (result_src),
    .alu_src_a           (alu_src_a),
    .alu_src_b           (alu_src_b),
    .alu_control         (alu_control)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] state;
    bit         last;
  } state_exp_t;

  typedef struct {
    string       name;
    int          kind;
    int          idx;
    logic [31:0] value;
    logic [31:0] pc;
  } result_exp_t;

  localparam int K_NONE = 0;
  localparam int K_REG  = 1;
  localparam int K_MEM  = 2;

  state_exp_t  st_q[$];
  result_exp_t res_q[$];
  int          checks = 0;
  int          passes = 0;
  logic [31:0] pc_model = 32'd0;
  bit          commit_pending = 1'b0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  // Queues the state walk and the committed result for one instruction, then runs it.
  task automatic apply_stimulus(input logic [31:0] ins, input int kind, input int idx,
                                input logic [31:0] value, input string name);
    int seq[$];
    result_exp_t r;
    case (ins[6:0])
      7'b0110011: seq = '{0, 1, 6, 7};
      7'b0010011: seq = '{0, 1, 8, 7};
      7'b0000011: seq = '{0, 1, 2, 3, 4};
      7'b0100011: seq = '{0, 1, 2, 5};
      default:    seq = '{0, 1};
    endcase
    foreach (seq[i]) begin
      state_exp_t s;
      s.state = seq[i][3:0];
      s.last  = (i == seq.size() - 1);
      st_q.push_back(s);
    end
    pc_model += 32'd4;
    r.name  = name;
    r.kind  = kind;
    r.idx   = idx;
    r.value = value;
    r.pc    = pc_model;
    res_q.push_back(r);
    instr = ins;
    repeat (seq.size()) @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (commit_pending && res_q.size() > 0) begin
        result_exp_t r;
        r = res_q.pop_front();
        commit_pending = 1'b0;
        check_output({r.name, " pc"}, d_pc_out, r.pc);
        if (r.kind == K_REG) check_output({r.name, " reg"}, dut.reg_file[r.idx], r.value);
        else if (r.kind == K_MEM) check_output({r.name, " mem"}, dut.mem[r.idx], r.value);
      end
      if (st_q.size() > 0) begin
        state_exp_t s;
        s = st_q.pop_front();
        check_output("state", {28'd0, current_state}, {28'd0, s.state});
        if (s.last) commit_pending = 1'b1;
      end
    end
  end

  initial begin
    reset = 1'b0;
    instr = 32'h00000013;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset pc", d_pc_out, 32'd0);
    check_output("reset state", {28'd0, current_state}, 32'd0);
    check_output("reset ir", instr_out, 32'd0);
    check_output("reset fetch ctrl",
                 {22'd0, ir_write, pc_write, mem_write, reg_write, alu_src_a, alu_src_b, result_src},
                 {22'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 2'b10});
    check_output("reset alu_control", {29'd0, alu_control}, 32'd0);
    reset = 1'b1;

    apply_stimulus(32'h00000013, K_NONE, 0, 32'd0, "nop");
    apply_stimulus(32'h01800093, K_REG, 1, 32'h18, "addi x1");
    apply_stimulus(32'h00100113, K_REG, 2, 32'h1, "addi x2");
    apply_stimulus(32'h002081B3, K_REG, 3, 32'h19, "add");
    apply_stimulus(32'h002081B3, K_REG, 3, 32'h19, "add again");
    apply_stimulus(32'h402081B3, K_REG, 3, 32'h17, "sub");
    apply_stimulus(32'h001121B3, K_REG, 3, 32'h1, "slt x2<x1");
    apply_stimulus(32'h0020A1B3, K_REG, 3, 32'h0, "slt x1<x2");
    apply_stimulus(32'hFFF00313, K_REG, 6, 32'hFFFFFFFF, "addi x6 -1");
    apply_stimulus(32'h001321B3, K_REG, 3, 32'h1, "slt signed");
    apply_stimulus(32'h0020E1B3, K_REG, 3, 32'h19, "or");
    apply_stimulus(32'h0020F1B3, K_REG, 3, 32'h0, "and");
    apply_stimulus(32'h01000113, K_REG, 2, 32'h10, "addi x2 0x10");
    apply_stimulus(32'h00112023, K_MEM, 4, 32'h18, "sw");
    apply_stimulus(32'h00012283, K_REG, 5, 32'h18, "lw");
    apply_stimulus(32'hFE112E23, K_MEM, 3, 32'h18, "sw neg offset");
    apply_stimulus(32'h00508013, K_REG, 0, 32'h0, "addi x0");
    apply_stimulus(32'hFFF08213, K_REG, 4, 32'h17, "addi x4 -1");
    apply_stimulus(32'h00000000, K_NONE, 0, 32'd0, "illegal op");

    // add x9,x1,x2 interrupted by reset while in EXECUTER.
    instr = 32'h002084B3;
    repeat (2) @(posedge clk);
    #1;
    check_output("pre-abort state", {28'd0, current_state}, 32'd6);
    reset = 1'b0;
    #1;
    check_output("abort state", {28'd0, current_state}, 32'd0);
    check_output("abort pc", d_pc_out, 32'd0);
    check_output("abort ir", instr_out, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_output("abort x9", dut.reg_file[9], 32'd0);
    check_output("abort x1 cleared", dut.reg_file[1], 32'd0);
    check_output("abort mem cleared", dut.mem[4], 32'd0);
    reset = 1'b1;
    pc_model = 32'd0;
    apply_stimulus(32'h00700393, K_REG, 7, 32'h7, "post-reset addi");

    for (int i = 0; i < 10 && (res_q.size() > 0 || st_q.size() > 0); i++) @(negedge clk);
    #1;
    if (res_q.size() > 0 || st_q.size() > 0) begin
      checks++;
      $display("[TB] FAIL drain: %0d results and %0d states left, expected 0 and 0",
               res_q.size(), st_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
